irrigation_matrix_scanner: RTL

//  Time-multiplexed LED-matrix driver for the irrigation-mode display. It scans a COLS x ROWS matrix
//  one column at a time, using a Y-axis-mirrored glyph ROM for sprinkler/dripper/fault/off modes.
//  The mode is latched only at frame boundaries, so the display never shows a mixed image.

---
 rtl/irrigation_display_pkg.sv | 52 +++++
 rtl/irrigation_matrix_scanner_timer.sv | 48 ++++
 rtl/irrigation_matrix_scanner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/irrigation_display_pkg.sv
// Shared types and glyph ROM for the irrigation-mode LED matrix display.
// Combinational lookup only; no latency, no flow control.
package irrigation_display_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_SPRINKLER = 2'b01,
        MODE_DRIPPER   = 2'b10,
        MODE_FAULT     = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 7;

    // g counts from the outermost stored column (0) to the centre column (GLYPH_W-1).
    function automatic logic [6:0] glyph_col(input mode_t m, input int g);
        logic [6:0] c;
        c = 7'b0000000;
        case (m)
            MODE_SPRINKLER: begin
                case (g)
                    0:       c = 7'b1011001;
                    1:       c = 7'b0011111;
                    2:       c = 7'b1111111;
                    default: c = 7'b0000000;
                endcase
            end
            MODE_DRIPPER: begin
                case (g)
                    0:       c = 7'b0001110;
                    1:       c = 7'b0100011;
                    2:       c = 7'b1111111;
                    default: c = 7'b0000000;
                endcase
            end
            MODE_FAULT: begin
                case (g)
                    2:       c = 7'b1111101;
                    default: c = 7'b0000000;
                endcase
            end
            default: c = 7'b0000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/irrigation_matrix_scanner_timer.sv
// Column-slot prescaler and column counter; flags slot start, dead time and frame wrap.
// Latency: flags are combinational from the counters; free-running, no backpressure.
module matrix_scan_timer #(
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 1000,
    parameter int DEAD     = 1,
    parameter int PW       = $clog2(SCAN_DIV),
    parameter int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clr,
    output logic [CW-1:0] col_idx,
    output logic          slot_start,
    output logic          dead,
    output logic          frame_wrap
);

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          col_wrap;

    assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
    assign col_wrap   = (col_idx == CW'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            col_idx <= '0;
        end else if (clr) begin
            presc   <= '0;
            col_idx <= '0;
        end else if (run) begin
            if (presc_wrap) begin
                presc   <= '0;
                col_idx <= col_wrap ? '0 : col_idx + CW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign slot_start = (presc == '0);
    assign dead       = (presc < PW'(DEAD));
    assign frame_wrap = run && presc_wrap && col_wrap;

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Column-multiplexed LED matrix driver showing a mirrored glyph per irrigation mode, fault blinks.
// Latency: outputs registered, one cycle after enable; no backpressure (free-running scan).
module irrigation_matrix_scanner
    import irrigation_display_pkg::*;
#(
    parameter int COLS         = 5,
    parameter int ROWS         = 7,
    parameter int MODE_W       = 2,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 25,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [MODE_W-1:0] mode,
    output logic [COLS-1:0]   col_sel,
    output logic [ROWS-1:0]   row_data,
    output logic              frame_start
);

    localparam int   FOLDS = (COLS + 1) / 2;
    localparam int   CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int   FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [CW-1:0]     col_idx;
    logic              slot_start;
    logic              dead;
    logic              frame_wrap;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_hi;
    logic              mode_illegal;
    logic              mode_load;
    logic [FW-1:0]     frame_cnt;
    logic              blink_on;
    logic [6:0]        glyph;
    logic [31:0]       glyph_w;
    int                col_i;
    int                fold_i;
    int                g_i;
    logic [COLS-1:0]   col_nxt;
    logic [ROWS-1:0]   row_nxt;
    logic              fs_nxt;

    matrix_scan_timer #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD     (DEAD),
        .PW       ($clog2(SCAN_DIV)),
        .CW       (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (enable),
        .clr        (!enable),
        .col_idx    (col_idx),
        .slot_start (slot_start),
        .dead       (dead),
        .frame_wrap (frame_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)  state_nxt = ST_SCAN;
            ST_SCAN: if (!enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mode is sampled only when a frame begins so a frame never mixes two glyphs.
    assign mode_load = ((state == ST_IDLE) && enable) || frame_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
        end else if (mode_load) begin
            mode_q <= mode;
        end
    end

    // Blink phase keeps running through mode changes; only disable or reset restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!enable) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign mode_hi      = mode_q >> 2;
    assign mode_illegal = |mode_hi;

    always_comb begin
        col_i   = int'(col_idx);
        fold_i  = (col_i < (COLS - 1 - col_i)) ? col_i : (COLS - 1 - col_i);
        g_i     = fold_i - (FOLDS - GLYPH_W);
        glyph   = glyph_col(mode_t'(mode_q[1:0]), g_i);
        glyph_w = 32'(glyph);
        col_nxt = '0;
        row_nxt = '0;
        fs_nxt  = 1'b0;
        if (state_nxt == ST_SCAN) begin
            fs_nxt = slot_start && (col_idx == '0);
            if (!dead) begin
                col_nxt = COLS'(1) << col_idx;
                if (!mode_illegal && !((mode_q[1:0] == MODE_FAULT) && !blink_on)) begin
                    for (int r = 0; r < ROWS; r++) begin
                        row_nxt[r] = (r < GLYPH_H) ? glyph_w[r] : 1'b0;
                    end
                end
            end
        end
    end

    // Pins hold their physical level; reset forces the inactive level asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_sel     <= {COLS{POL}};
            row_data    <= {ROWS{POL}};
            frame_start <= 1'b0;
        end else begin
            col_sel     <= col_nxt ^ {COLS{POL}};
            row_data    <= row_nxt ^ {ROWS{POL}};
            frame_start <= fs_nxt;
        end
    end

    a_col_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(col_sel ^ {COLS{POL}}));

endmodule
